muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the execute stage, beside alu.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/muldiv_sign.sv | 19 +
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension funct3 codes, multiply/divide FSM encodings
// and the default datapath width.
package riscv_pkg;

    localparam int MULDIV_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] MULDIV_IDLE = 2'b00;
    localparam logic [1:0] MULDIV_CALC = 2'b01;
    localparam logic [1:0] MULDIV_FAST = 2'b10;

endpackage

// File: rtl/muldiv_sign.sv
// Two-lane conditional two's-complement negate. On the input side it turns signed
// operands into magnitudes; on the output side it applies the sign fix-up.
module muldiv_sign #(
    parameter int WX = 32,
    parameter int WY = 32
) (
    input  logic [WX-1:0] x_in,
    input  logic          x_neg,
    input  logic [WY-1:0] y_in,
    input  logic          y_neg,
    output logic [WX-1:0] x_out,
    output logic [WY-1:0] y_out
);

    // Negating the most negative value yields itself, which is the correct unsigned magnitude
    assign x_out = x_neg ? ({WX{1'b0}} - x_in) : x_in;
    assign y_out = y_neg ? ({WY{1'b0}} - y_in) : y_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit. A single 2*XLEN accumulator holds
// {hi, multiplier} for multiplies and {remainder, quotient} for divides.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [1:0]        state_r;
    logic [2:0]        op_r;
    logic              a_neg_r;
    logic              b_neg_r;
    logic [XLEN-1:0]   opnd_r;
    logic [2*XLEN-1:0] acc_r;
    logic [CNT_W-1:0]  count_r;
    logic [XLEN-1:0]   result_r;
    logic              busy_r;
    logic              done_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_sign_s;
    logic              b_sign_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              b_zero_s;
    logic              ovf_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_val_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [2*XLEN-1:0] fix_x_in_s;
    logic [2*XLEN-1:0] fix_x_s;
    logic [XLEN-1:0]   fix_rem_s;
    logic [XLEN-1:0]   calc_res_s;

    assign a_signed_s = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                        (op == OP_DIV) || (op == OP_REM);
    assign b_signed_s = (op == OP_MUL) || (op == OP_MULH) ||
                        (op == OP_DIV) || (op == OP_REM);
    assign a_sign_s   = a_signed_s & a[XLEN-1];
    assign b_sign_s   = b_signed_s & b[XLEN-1];

    muldiv_sign #(.WX(XLEN), .WY(XLEN)) u_sign_in (
        .x_in  (a),
        .x_neg (a_sign_s),
        .y_in  (b),
        .y_neg (b_sign_s),
        .x_out (a_mag_s),
        .y_out (b_mag_s)
    );

    assign b_zero_s = (b == {XLEN{1'b0}});
    assign ovf_s    = ((op == OP_DIV) || (op == OP_REM)) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
    assign fast_s   = op[2] & (b_zero_s | ovf_s);

    // Early-out value for divide by zero and signed overflow; op[1] separates REM* from DIV*
    always_comb begin
        fast_val_s = {XLEN{1'b0}};
        if (b_zero_s) begin
            fast_val_s = op[1] ? a : {XLEN{1'b1}};
        end else begin
            fast_val_s = op[1] ? {XLEN{1'b0}} : a;
        end
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) iteration
    always_comb begin
        sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        diff_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opnd_r};
        step_s = {2*XLEN{1'b0}};
        if (op_r[2]) begin
            if (!diff_s[XLEN]) begin
                step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                step_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else begin
            step_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    assign count_next_s = count_r + CNT_W'(1'b1);
    assign fix_x_in_s   = op_r[2] ? {{XLEN{1'b0}}, step_s[XLEN-1:0]} : step_s;

    muldiv_sign #(.WX(2*XLEN), .WY(XLEN)) u_sign_out (
        .x_in  (fix_x_in_s),
        .x_neg (a_neg_r ^ b_neg_r),
        .y_in  (step_s[2*XLEN-1:XLEN]),
        .y_neg (a_neg_r),
        .x_out (fix_x_s),
        .y_out (fix_rem_s)
    );

    // Select the architectural result slice for the latched operation
    always_comb begin
        calc_res_s = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:                       calc_res_s = fix_x_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_res_s = fix_x_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              calc_res_s = fix_x_s[XLEN-1:0];
            OP_REM, OP_REMU:              calc_res_s = fix_rem_s;
            default:                      calc_res_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and datapath registers; flush overrides both start and completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MULDIV_IDLE;
            op_r     <= 3'b000;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            opnd_r   <= {XLEN{1'b0}};
            acc_r    <= {2*XLEN{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            result_r <= {XLEN{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (flush) begin
            state_r <= MULDIV_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                MULDIV_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        a_neg_r <= a_sign_s;
                        b_neg_r <= b_sign_s;
                        opnd_r  <= op[2] ? b_mag_s : a_mag_s;
                        if (fast_s) begin
                            acc_r <= {{XLEN{1'b0}}, fast_val_s};
                        end else begin
                            acc_r <= {{XLEN{1'b0}}, (op[2] ? a_mag_s : b_mag_s)};
                        end
                        count_r <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= fast_s ? MULDIV_FAST : MULDIV_CALC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MULDIV_CALC: begin
                    acc_r   <= step_s;
                    count_r <= count_next_s;
                    if (count_next_s == CNT_W'(XLEN)) begin
                        result_r <= calc_res_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= MULDIV_IDLE;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                MULDIV_FAST: begin
                    result_r <= acc_r[XLEN-1:0];
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= MULDIV_IDLE;
                end
                default: begin
                    state_r <= MULDIV_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule
